// File: rtl/alu_pkg.sv
// Shared opcode constants and controller state encoding for the sequential ALU.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package alu_pkg;

   localparam logic [3:0] ALU_AND  = 4'd0;
   localparam logic [3:0] ALU_OR   = 4'd1;
   localparam logic [3:0] ALU_XOR  = 4'd2;
   localparam logic [3:0] ALU_XNOR = 4'd3;
   localparam logic [3:0] ALU_ADD  = 4'd4;
   localparam logic [3:0] ALU_SUB  = 4'd5;
   localparam logic [3:0] ALU_SLTU = 4'd6;
   localparam logic [3:0] ALU_SLL  = 4'd7;
   localparam logic [3:0] ALU_SRL  = 4'd8;
   localparam logic [3:0] ALU_SRA  = 4'd9;
   localparam logic [3:0] ALU_SLT  = 4'd10;
   localparam logic [3:0] ALU_MUL  = 4'd11;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      MUL_BUSY = 2'd1,
      HOLD     = 2'd2
   } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-and-add multiplier, low WIDTH bits of the product.
// Latency: WIDTH cycles after i_start; o_done flags the final iteration cycle.
// Backpressure: none; the owner must hold the result itself once o_done fires.
module alu_mul_iter
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic             o_done,
   output logic [WIDTH-1:0] o_prod
);

   localparam int CW = $clog2(WIDTH);

   logic             r_busy;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0] r_mplier;
   logic [WIDTH-1:0] w_acc_nxt;

   // o_prod already includes the last partial product, so the owner can
   // capture it on the same edge that retires the final iteration.
   assign w_acc_nxt = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
   assign o_done    = r_busy && (r_cnt == CW'(WIDTH - 1));
   assign o_prod    = w_acc_nxt;

   // One multiplier bit per cycle: add shifted multiplicand when the bit is set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy   <= 1'b0;
         r_cnt    <= '0;
         r_acc    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
      end else if (i_start) begin
         r_busy   <= 1'b1;
         r_cnt    <= '0;
         r_acc    <= '0;
         r_mcand  <= i_a;
         r_mplier <= i_b;
      end else if (r_busy) begin
         r_acc    <= w_acc_nxt;
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         r_cnt    <= r_cnt + CW'(1);
         if (o_done) begin
            r_busy <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with registered result/flags and a valid/ready handshake on both sides.
// Latency: 1 cycle for single-cycle ops and illegal opcodes, WIDTH+1 cycles for MUL.
// Backpressure: result and flags held in HOLD until out_ready; in_ready only in IDLE.
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [3:0]       ALU_OP,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] F,
   output logic             ZF,
   output logic             OF,
   output logic             CF,
   output logic             NF,
   output logic             ERR
);

   state_t           r_state;
   state_t           w_state_nxt;
   logic             w_accept;
   logic             w_mul_start;
   logic             w_mul_done;
   logic [WIDTH-1:0] w_mul_prod;
   logic [SHW-1:0]   w_shamt;
   logic [WIDTH-1:0] w_f;
   logic             w_cf;
   logic             w_of;
   logic             w_err;
   logic             w_load;
   logic [WIDTH-1:0] r_f;
   logic             r_zf;
   logic             r_of;
   logic             r_cf;
   logic             r_nf;
   logic             r_err;

   assign w_shamt = A[SHW-1:0];

   alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_start (w_mul_start),
      .i_a     (A),
      .i_b     (B),
      .o_done  (w_mul_done),
      .o_prod  (w_mul_prod)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state and handshake outputs; at most one operation in flight.
   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      w_accept    = 1'b0;
      w_mul_start = 1'b0;
      case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               w_accept = 1'b1;
               if (ALU_OP == ALU_MUL) begin
                  w_mul_start = 1'b1;
                  w_state_nxt = MUL_BUSY;
               end else begin
                  w_state_nxt = HOLD;
               end
            end
         end
         MUL_BUSY: begin
            if (w_mul_done) begin
               w_state_nxt = HOLD;
            end
         end
         HOLD: begin
            out_valid = 1'b1;
            if (out_ready) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Result and carry/overflow/error selection; multiplier output wins while busy.
   always_comb begin
      w_f   = '0;
      w_cf  = 1'b0;
      w_of  = 1'b0;
      w_err = 1'b0;
      if (r_state == MUL_BUSY) begin
         w_f = w_mul_prod;
      end else begin
         case (ALU_OP)
            ALU_AND:  w_f = A & B;
            ALU_OR:   w_f = A | B;
            ALU_XOR:  w_f = A ^ B;
            ALU_XNOR: w_f = ~(A ^ B);
            ALU_ADD: begin
               {w_cf, w_f} = {1'b0, A} + {1'b0, B};
               w_of = (A[WIDTH-1] == B[WIDTH-1]) && (w_f[WIDTH-1] != A[WIDTH-1]);
            end
            ALU_SUB: begin
               w_f  = A - B;
               w_cf = (A < B);
               w_of = (A[WIDTH-1] != B[WIDTH-1]) && (w_f[WIDTH-1] != A[WIDTH-1]);
            end
            ALU_SLTU: w_f = WIDTH'(A < B);
            ALU_SLL:  w_f = B << w_shamt;
            ALU_SRL:  w_f = B >> w_shamt;
            ALU_SRA:  w_f = $signed(B) >>> w_shamt;
            ALU_SLT:  w_f = WIDTH'($signed(A) < $signed(B));
            ALU_MUL:  w_f = '0;
            default:  w_err = 1'b1;
         endcase
      end
   end

   assign w_load = (w_accept && (ALU_OP != ALU_MUL)) || w_mul_done;

   // Result registers: written once per operation, then frozen through HOLD.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_f   <= '0;
         r_zf  <= 1'b0;
         r_of  <= 1'b0;
         r_cf  <= 1'b0;
         r_nf  <= 1'b0;
         r_err <= 1'b0;
      end else if (w_load) begin
         r_f   <= w_f;
         r_zf  <= (w_f == '0);
         r_of  <= w_of;
         r_cf  <= w_cf;
         r_nf  <= w_f[WIDTH-1];
         r_err <= w_err;
      end
   end

   assign F   = r_f;
   assign ZF  = r_zf;
   assign OF  = r_of;
   assign CF  = r_cf;
   assign NF  = r_nf;
   assign ERR = r_err;

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits (power of two, 8..64).
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), shift-amount width.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  operation request present.
REQ-006 SHALL have port in_ready  output  1  block accepts a request this cycle.
REQ-007 SHALL have port A  input  WIDTH  operand A (shift amount for shift ops).
REQ-008 SHALL have port B  input  WIDTH  operand B (shifted value for shift ops).
REQ-009 SHALL have port ALU_OP  input  4  operation code.
REQ-010 SHALL have port out_valid  output  1  result registers hold a valid result.
REQ-011 SHALL have port out_ready  input  1  consumer takes result this cycle.
REQ-012 SHALL have port F  output  WIDTH  result.
REQ-013 SHALL have port ZF, OF, CF, NF, ERR  output  1 each  zero, signed overflow, carry/borrow, sign (F[WIDTH-1]), illegal opcode.

Function
REQ-014 SHALL decode ALU_OP: 0 AND, 1 OR, 2 XOR, 3 XNOR, 4 ADD, 5 SUB (A-B), 6 SLTU (F=1 if A<B unsigned else 0), 7 SLL (B<<A[SHW-1:0]), 8 SRL, 9 SRA (B>>>A[SHW-1:0]), 10 SLT signed, 11 MUL (low WIDTH bits of A*B), 12-15 illegal.
REQ-015 SHALL implement FSM states IDLE, MUL_BUSY, HOLD; in_ready=1 only in IDLE.
REQ-016 SHALL accept a request on a cycle with in_valid=1 and in_ready=1, capturing A, B, ALU_OP.
REQ-017 SHALL, for any accepted non-MUL op, register the result and flags at the accepting edge and enter HOLD (out_valid=1 the next cycle, latency 1).
REQ-018 SHALL, for accepted MUL, enter MUL_BUSY and run shift-and-add one multiplier bit per cycle, entering HOLD after exactly WIDTH busy cycles (out_valid WIDTH+1 cycles after acceptance).
REQ-019 SHALL hold F and all flags stable in HOLD until out_ready=1; on that edge return to IDLE and drop out_valid.
REQ-020 SHALL NOT accept a new request in the HOLD->IDLE cycle (no bypass; one in flight, max one op per two cycles).
REQ-021 SHALL set CF to carry-out for ADD, to borrow (A<B unsigned) for SUB, and 0 for all other ops.
REQ-022 SHALL set OF to signed overflow for ADD (same-sign operands, differing result sign) and SUB (opposite-sign operands, result sign differs from A), 0 otherwise including MUL truncation.
REQ-023 SHALL set ZF=1 iff F==0 and NF=F[WIDTH-1], for every op.
REQ-024 SHALL, for illegal opcodes, complete with latency 1, F=0, ZF=1, ERR=1, other flags 0; ERR=0 for legal ops.
REQ-025 SHALL use only A[SHW-1:0] as shift amount; upper A bits ignored.
REQ-026 SHALL ignore in_valid and input changes while in MUL_BUSY or HOLD.

Reset
REQ-027 SHALL, on rst_n=0, asynchronously force state IDLE, F=0, ZF=0, OF=0, CF=0, NF=0, ERR=0, out_valid=0, multiply counter and accumulator 0.
REQ-028 SHALL abort an in-progress MUL on reset with no result produced; in_ready=1 on the first edge after rst_n deasserts.

Structure
REQ-029 SHALL place opcode constants (ALU_AND..ALU_MUL) and FSM state encodings in shared package alu_pkg.
REQ-030 SHALL place the iterative multiplier in sub-module alu_mul_iter (start, done, WIDTH parameter); all other ops combinational in alu_seq.

Verification
REQ-031 SHALL verify ADD WIDTH=32: A=32'h7FFFFFFF, B=1 -> F=32'h80000000, OF=1, CF=0, NF=1, out_valid one cycle after acceptance.
REQ-032 SHALL verify SUB: A=0, B=1 -> F=32'hFFFFFFFF, CF=1, OF=0, ZF=0; A=B=5 -> F=0, ZF=1.
REQ-033 SHALL verify MUL: A=32'h0001_0001, B=32'h0001_0000 -> F=32'h0001_0000 exactly 33 cycles after acceptance, in_ready=0 throughout.
REQ-034 SHALL verify backpressure: out_ready=0 for 5 cycles after SRA A=4, B=32'h8000_0000 -> F=32'hF800_0000 held stable, in_valid pulses ignored.
REQ-035 SHALL verify reset mid-MUL (cycle 10 of busy) -> outputs zero, out_valid=0, next request completes correctly.
REQ-036 SHALL verify ALU_OP=4'hF -> F=0, ZF=1, ERR=1; then SLT A=-1, B=0 -> F=1, ERR=0.
